// File: rtl/cic_mc_decim.sv
// Multi-channel CIC decimator: per-channel integrators at input rate, one
// time-multiplexed comb engine per output tick, registered-output FIFO.
// Optional build macro CIC_MC_ROUND_EN: round half up and saturate at NORM
// (default build truncates and wraps).
module cic_mc_decim #(
  parameter int CHANNELS   = 4,
  parameter int STAGES     = 5,
  parameter int IN_WIDTH   = 18,
  parameter int GROWTH     = 70,
  parameter int OUT_WIDTH  = 24,
  parameter int MD         = 14,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        cfg_load,
  input  logic [MD-1:0]                               cfg_decim,
  input  logic [$clog2(IN_WIDTH+GROWTH)-1:0]          cfg_shift,
  input  logic                                        in_strobe,
  input  logic [CHANNELS*IN_WIDTH-1:0]                in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
  output logic [OUT_WIDTH-1:0]                        out_data,
  output logic                                        out_last,
  output logic                                        overflow
);
  localparam int ACC_W = IN_WIDTH + GROWTH;
  localparam int SW    = $clog2(ACC_W);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SGW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int WUW   = $clog2(STAGES + 1);
  localparam int FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW   = FAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_COMB, S_NORM, S_WRITE} state_t;

  logic [ACC_W-1:0]     r_integ [CHANNELS][STAGES];
  logic [ACC_W-1:0]     w_isum  [CHANNELS][STAGES];
  logic [ACC_W-1:0]     r_snap  [CHANNELS];
  logic [ACC_W-1:0]     r_z     [CHANNELS][STAGES];
  logic [MD-1:0]        r_cnt, r_rm1, r_pend_decim, w_pend_rm1;
  logic [SW-1:0]        r_shift, r_pend_shift, r_fshift;
  logic                 r_pend, r_tick_d, r_zclr, r_frame_zclr, r_frame_wr, r_ov;
  logic [WUW-1:0]       r_warm;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_ch;
  logic [SGW-1:0]       r_stg;
  logic [ACC_W-1:0]     r_x, w_cx, w_cz, w_cy;
  logic [OUT_WIDTH-1:0] r_res, w_norm;
  logic signed [ACC_W:0] w_rnd, w_shd;
  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [CW-1:0]        r_mem_chan [FIFO_DEPTH];
  logic                 r_mem_last [FIFO_DEPTH];
  logic [FAW-1:0]       r_wp, r_rp;
  logic [FCW-1:0]       r_fcnt;
  logic                 r_valid, r_olast;
  logic [CW-1:0]        r_ochan;
  logic [OUT_WIDTH-1:0] r_odata;
  logic                 w_tick, w_apply, w_free_ok, w_start, w_drop;
  logic                 w_last_ch, w_last_stg, w_push, w_wr, w_pop;

  assign w_tick     = in_strobe && (r_cnt == r_rm1);
  assign w_apply    = w_tick && r_pend;
  assign w_pend_rm1 = (r_pend_decim == '0) ? '0 : r_pend_decim - MD'(1);
  assign w_free_ok  = (r_fcnt <= FCW'(FIFO_DEPTH - CHANNELS));
  assign w_start    = r_tick_d && (r_state == S_IDLE) && w_free_ok;
  assign w_drop     = r_tick_d && !w_start;
  assign w_last_ch  = (r_ch == CW'(CHANNELS - 1));
  assign w_last_stg = (r_stg == SGW'(STAGES - 1));
  assign w_push     = (r_state == S_WRITE) && r_frame_wr;
  assign w_pop      = r_valid && out_ready;
  assign w_wr       = w_push && ((r_fcnt != FCW'(FIFO_DEPTH)) || w_pop);

  // integrator cascade: every stage sees this strobe's update of the stage below
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_isum[c][0] = r_integ[c][0] + ACC_W'($signed(in_data[c*IN_WIDTH +: IN_WIDTH]));
      for (int unsigned s = 1; s < STAGES; s++)
        w_isum[c][s] = r_integ[c][s] + w_isum[c][s-1];
    end
  end

  // integrator state: cleared on config apply, otherwise advanced per strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned s = 0; s < STAGES; s++) r_integ[c][s] <= '0;
    end else if (w_apply) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned s = 0; s < STAGES; s++) r_integ[c][s] <= '0;
    end else if (in_strobe) begin
      r_integ <= w_isum;
    end
  end

  // configuration, sample counter, tick pipeline, warm-up and overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0; r_pend_decim <= '0; r_pend_shift <= '0;
      r_rm1 <= '0; r_shift <= '0; r_cnt <= '0; r_tick_d <= 1'b0;
      r_zclr <= 1'b0; r_warm <= WUW'(STAGES); r_ov <= 1'b0;
    end else begin
      if (w_apply) begin
        r_pend  <= 1'b0;
        r_rm1   <= w_pend_rm1;
        r_shift <= r_pend_shift;
        r_cnt   <= '0;
      end else if (in_strobe) begin
        r_cnt <= w_tick ? '0 : r_cnt + MD'(1);
      end
      // a load in the apply cycle stays pending for the following tick
      if (cfg_load) begin
        r_pend <= 1'b1; r_pend_decim <= cfg_decim; r_pend_shift <= cfg_shift;
      end
      r_tick_d <= w_tick && !r_pend;
      // comb delays are zeroed lazily by the next frame so an in-flight frame finishes intact
      if (w_apply) r_zclr <= 1'b1;
      else if (w_start) r_zclr <= 1'b0;
      if (w_apply) r_warm <= WUW'(STAGES);
      else if (w_start && (r_warm != '0)) r_warm <= r_warm - WUW'(1);
      if (w_drop) r_ov <= 1'b1;
    end
  end

  // engine state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // engine next-state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_COMB;
      S_COMB:  if (w_last_stg) w_next = S_NORM;
      S_NORM:  w_next = S_WRITE;
      S_WRITE: w_next = w_last_ch ? S_IDLE : S_COMB;
      default: w_next = S_IDLE;
    endcase
  end

  // comb stage arithmetic and output normalisation
  always_comb begin
    w_cx = (r_stg == '0) ? r_snap[r_ch] : r_x;
    w_cz = r_frame_zclr ? '0 : r_z[r_ch][r_stg];
    w_cy = w_cx - w_cz;
    w_rnd = $signed({r_x[ACC_W-1], r_x});
`ifdef CIC_MC_ROUND_EN
    if (r_fshift != '0) w_rnd = w_rnd + ((ACC_W+1)'(1) << (r_fshift - SW'(1)));
    w_shd = w_rnd >>> r_fshift;
    if (w_shd > $signed({{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}}))
      w_norm = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (w_shd < $signed({{(ACC_W+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}}))
      w_norm = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      w_norm = w_shd[OUT_WIDTH-1:0];
`else
    w_shd  = w_rnd >>> r_fshift;
    w_norm = w_shd[OUT_WIDTH-1:0];
`endif
  end

  // engine datapath: snapshot, per-(ch,stg) delays, sequencing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_snap[c] <= '0;
        for (int unsigned s = 0; s < STAGES; s++) r_z[c][s] <= '0;
      end
      r_ch <= '0; r_stg <= '0; r_x <= '0; r_res <= '0;
      r_fshift <= '0; r_frame_wr <= 1'b0; r_frame_zclr <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) begin
          for (int unsigned c = 0; c < CHANNELS; c++) r_snap[c] <= r_integ[c][STAGES-1];
          r_ch <= '0; r_stg <= '0;
          r_fshift <= r_shift;
          r_frame_wr <= (r_warm == '0);
          r_frame_zclr <= r_zclr;
        end
        S_COMB: begin
          r_z[r_ch][r_stg] <= w_cx;
          r_x   <= w_cy;
          r_stg <= w_last_stg ? '0 : r_stg + SGW'(1);
        end
        S_NORM:  r_res <= w_norm;
        S_WRITE: r_ch <= r_ch + CW'(1);
        default: ;
      endcase
    end
  end

  // output FIFO with registered head
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0; r_mem_chan[i] <= '0; r_mem_last[i] <= 1'b0;
      end
      r_wp <= '0; r_rp <= '0; r_fcnt <= '0;
      r_valid <= 1'b0; r_odata <= '0; r_ochan <= '0; r_olast <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem_data[r_wp] <= r_res; r_mem_chan[r_wp] <= r_ch; r_mem_last[r_wp] <= w_last_ch;
        r_wp <= r_wp + FAW'(1);
      end
      if (w_pop) r_rp <= r_rp + FAW'(1);
      r_fcnt  <= r_fcnt + FCW'(w_wr) - FCW'(w_pop);
      r_valid <= (r_fcnt + FCW'(w_wr) - FCW'(w_pop)) != '0;
      if (w_wr && ((r_fcnt == '0) || ((r_fcnt == FCW'(1)) && w_pop))) begin
        r_odata <= r_res; r_ochan <= r_ch; r_olast <= w_last_ch;
      end else if (w_pop && (r_fcnt > FCW'(1))) begin
        r_odata <= r_mem_data[r_rp + FAW'(1)];
        r_ochan <= r_mem_chan[r_rp + FAW'(1)];
        r_olast <= r_mem_last[r_rp + FAW'(1)];
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_odata;
  assign out_chan  = r_ochan;
  assign out_last  = r_olast;
  assign overflow  = r_ov;
endmodule

// File: tb/tb_cic_mc_decim.sv
module tb_cic_mc_decim;
  localparam int CH = 2, NS = 3, IW = 18, OW = 24, MD = 14, SW = 7, DEPTH = 4, GAP = 3;

  logic clk = 1'b0, rst_n = 1'b0, cfg_load = 1'b0, in_strobe = 1'b0, out_ready = 1'b1;
  logic [MD-1:0]    cfg_decim = '0;
  logic [SW-1:0]    cfg_shift = '0;
  logic [CH*IW-1:0] in_data = '0;
  logic             out_valid, out_last, overflow;
  logic [0:0]       out_chan;
  logic [OW-1:0]    out_data;

  cic_mc_decim #(.CHANNELS(CH), .STAGES(NS), .IN_WIDTH(IW), .GROWTH(70), .OUT_WIDTH(OW),
                 .MD(MD), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clk), .reset(rst_n), .cfg_load(cfg_load), .cfg_decim(cfg_decim),
    .cfg_shift(cfg_shift), .in_strobe(in_strobe), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .out_last(out_last), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct packed {logic [OW-1:0] data; logic [0:0] chan; logic last;} exp_t;
  exp_t   q[$];
  int     n_pass = 0, n_total = 0;
  longint h[$];
  longint xs[CH][0:255];
  int     n_samp = 0, cur_r = 1, cur_shift = 0, frame = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // impulse response of N cascaded length-R boxcars
  task automatic build_h(input int r);
    longint t[$];
    h = {1};
    for (int n = 0; n < NS; n++) begin
      t = {};
      for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int k = 0; k < r; k++) t[i+k] += h[i];
      h = t;
    end
  endtask

  function automatic logic [OW-1:0] model_out(input int c, input int n);
    longint acc = 0;
    for (int j = 0; j < h.size(); j++)
      if (n - j >= 0) acc += h[j] * xs[c][n-j];
`ifdef CIC_MC_ROUND_EN
    if (cur_shift > 0) acc += longint'(1) <<< (cur_shift - 1);
    acc = acc >>> cur_shift;
    if (acc > 8388607) acc = 8388607;
    if (acc < -8388608) acc = -8388608;
`else
    acc = acc >>> cur_shift;
`endif
    return acc[OW-1:0];
  endfunction

  // load config, then strobe zeros until the old counter wraps and it applies
  task automatic apply_cfg(input int r, input int sh, input int old_r);
    cfg_load = 1'b1; cfg_decim = MD'(r); cfg_shift = SW'(sh);
    step();
    cfg_load = 1'b0;
    in_data = '0;
    for (int i = 0; i < old_r; i++) begin
      in_strobe = 1'b1; step(); in_strobe = 1'b0;
      repeat (GAP - 1) step();
    end
    cur_r = r; cur_shift = sh; n_samp = 0; frame = 0;
    build_h(r);
  endtask

  task automatic run_frames(input int nfr, input longint a, input longint b,
                            input int imp, input int store_lim);
    int stored = 0;
    longint x0;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < cur_r; i++) begin
        x0 = (imp >= 0) ? ((n_samp == imp) ? a : 0) : a;
        xs[0][n_samp] = x0; xs[1][n_samp] = b;
        in_data = {IW'(b), IW'(x0)};
        in_strobe = 1'b1; step(); in_strobe = 1'b0;
        repeat (GAP - 1) step();
        n_samp++;
      end
      frame++;
      if (frame > NS && stored < store_lim) begin
        for (int c = 0; c < CH; c++)
          q.push_back('{data: model_out(c, n_samp - 1), chan: 1'(c), last: (c == CH - 1)});
        stored++;
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) step();
    repeat (20) step();
    chk(tag, q.size(), 0);
  endtask

  // scoreboard: compare every accepted output against the head of the queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_total++;
      assert (q.size() != 0) n_pass++;
      else $error("FAIL unexpected_output: observed chan %0d data %0d expected none", out_chan, out_data);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_chan", out_chan, e.chan);
        chk("out_last", out_last, e.last);
      end
    end
  end

  initial begin
    #500000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step();

    // DC gain R**N=64 with shift 6
    apply_cfg(4, 6, 1);
    run_frames(6, 1000, -1000, -1, 99);
    drain("dc_drain");

    // fractional results: floor (or round) at the output shift
    apply_cfg(4, 7, 4);
    run_frames(5, 3, -3, -1, 99);
    drain("frac_drain");

    // impulse on ch0 after warm-up, ch1 silent
    apply_cfg(5, 0, 4);
    run_frames(7, 1, 0, 16, 99);
    drain("imp_drain");
    chk("ovf_clear", overflow, 0);

    // backpressure: two frames fill the FIFO, the third is dropped
    out_ready = 1'b0;
    apply_cfg(4, 6, 5);
    run_frames(6, 1000, -1000, -1, 2);
    repeat (20) step();
    chk("bp_ovf", overflow, 1);
    chk("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    drain("bp_drain");

    // reset pulse in the middle of the engine
    apply_cfg(4, 6, 4);
    run_frames(4, 500, -500, -1, 0);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step();
    q.delete();
    apply_cfg(4, 6, 1);
    run_frames(5, 1000, -1000, -1, 99);
    drain("post_rst_drain");
    chk("final_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
